cnn_tile_sched: RTL and testbench

//  Loop-nest controller for the tiled CNN conv layer. Walks row, col, output-map tile (to),

---
 rtl/cnn_tile_sched_if.sv | 47 ++++
 rtl/cnn_tile_sched.sv | 204 ++++++++++++++++++++
 tb/tb_cnn_tile_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_tile_sched_if.sv
// Beat bus between the tile scheduler and the Tm_p x Tn_p MAC engine.
// The scheduler is the master (drives indices and flags), the engine is the
// slave (drives ready_i). Index widths never collapse to zero bits, so a
// single-row or single-map configuration still has a usable port.
interface cnn_tile_sched_if #(
  parameter int N_p  = 4,
  parameter int M_p  = 4,
  parameter int K_p  = 2,
  parameter int R_p  = 16,
  parameter int C_p  = 16,
  parameter int S_p  = 1,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2
);
  localparam int ROW_W = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int COL_W = (C_p > 1) ? $clog2(C_p) : 1;
  localparam int TO_W  = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int TI_W  = (N_p > 1) ? $clog2(N_p) : 1;
  localparam int K_W   = $clog2(K_p) + 1;
  localparam int IR_W  = ((R_p * S_p + K_p) > 1) ? $clog2(R_p * S_p + K_p) : 1;
  localparam int IC_W  = ((C_p * S_p + K_p) > 1) ? $clog2(C_p * S_p + K_p) : 1;

  logic             valid_o;
  logic             ready_i;
  logic [ROW_W-1:0] row_o;
  logic [COL_W-1:0] col_o;
  logic [TO_W-1:0]  to_o;
  logic [TI_W-1:0]  ti_o;
  logic [K_W-1:0]   ki_o;
  logic [K_W-1:0]   kj_o;
  logic [IR_W-1:0]  in_row_o;
  logic [IC_W-1:0]  in_col_o;
  logic             first_o;
  logic             last_o;

  modport master (
    output valid_o, row_o, col_o, to_o, ti_o, ki_o, kj_o,
           in_row_o, in_col_o, first_o, last_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, row_o, col_o, to_o, ti_o, ki_o, kj_o,
           in_row_o, in_col_o, first_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/cnn_tile_sched.sv
// Loop-nest controller for the tiled CNN conv layer. Walks row, col, output
// tile, input tile, kernel row and kernel col, issuing one engine beat per
// cycle. Every output comes straight from a flop: the next-cycle values of the
// flags and input coordinates are computed alongside the counter update, so
// ready_i never reaches an output combinationally.
module cnn_tile_sched #(
  parameter int N_p  = 4,
  parameter int M_p  = 4,
  parameter int K_p  = 2,
  parameter int R_p  = 16,
  parameter int C_p  = 16,
  parameter int S_p  = 1,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic done_o,
  cnn_tile_sched_if.master beat
);

  localparam int ROW_W = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int COL_W = (C_p > 1) ? $clog2(C_p) : 1;
  localparam int TO_W  = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int TI_W  = (N_p > 1) ? $clog2(N_p) : 1;
  localparam int K_W   = $clog2(K_p) + 1;
  localparam int IR_W  = ((R_p * S_p + K_p) > 1) ? $clog2(R_p * S_p + K_p) : 1;
  localparam int IC_W  = ((C_p * S_p + K_p) > 1) ? $clog2(C_p * S_p + K_p) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(R_p - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(C_p - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(M_p - Tm_p);
  localparam logic [TI_W-1:0]  TI_LAST  = TI_W'(N_p - Tn_p);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(K_p - 1);
  localparam logic [TO_W-1:0]  TO_STEP  = TO_W'(Tm_p);
  localparam logic [TI_W-1:0]  TI_STEP  = TI_W'(Tn_p);

  // Tiles must divide the map counts evenly or the wrap points are never hit.
  if ((N_p % Tn_p) != 0) begin : g_bad_tn
    $error("cnn_tile_sched: N_p must be a multiple of Tn_p");
  end
  if ((M_p % Tm_p) != 0) begin : g_bad_tm
    $error("cnn_tile_sched: M_p must be a multiple of Tm_p");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [TI_W-1:0]  ti_q, ti_d;
  logic [K_W-1:0]   ki_q, ki_d;
  logic [K_W-1:0]   kj_q, kj_d;
  logic [IR_W-1:0]  in_row_q, in_row_d;
  logic [IC_W-1:0]  in_col_q, in_col_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic kj_wrap, ki_wrap, ti_wrap, to_wrap, col_wrap, row_wrap;
  logic c_ki, c_ti, c_to, c_col, c_row, final_beat;

  // valid_q mirrors state RUN, so this is the valid && ready acceptance.
  assign accept = valid_q && beat.ready_i;

  assign kj_wrap  = (kj_q  == K_LAST);
  assign ki_wrap  = (ki_q  == K_LAST);
  assign ti_wrap  = (ti_q  == TI_LAST);
  assign to_wrap  = (to_q  == TO_LAST);
  assign col_wrap = (col_q == COL_LAST);
  assign row_wrap = (row_q == ROW_LAST);

  // Carry chain: each counter steps only when everything inside it wraps.
  assign c_ki       = kj_wrap;
  assign c_ti       = c_ki  && ki_wrap;
  assign c_to       = c_ti  && ti_wrap;
  assign c_col      = c_to  && to_wrap;
  assign c_row      = c_col && col_wrap;
  assign final_beat = c_row && row_wrap;

  // Next state, counter advance on accept, and next-cycle output values.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    to_d    = to_q;
    ti_d    = ti_q;
    ki_d    = ki_q;
    kj_d    = kj_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          to_d    = '0;
          ti_d    = '0;
          ki_d    = '0;
          kj_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          kj_d = kj_wrap ? '0 : kj_q + K_W'(1);
          if (c_ki)  ki_d  = ki_wrap  ? '0 : ki_q + K_W'(1);
          if (c_ti)  ti_d  = ti_wrap  ? '0 : ti_q + TI_STEP;
          if (c_to)  to_d  = to_wrap  ? '0 : to_q + TO_STEP;
          if (c_col) col_d = col_wrap ? '0 : col_q + COL_W'(1);
          if (c_row) row_d = row_wrap ? '0 : row_q + ROW_W'(1);
          if (final_beat) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
        to_d    = '0;
        ti_d    = '0;
        ki_d    = '0;
        kj_d    = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides both start and the handshake.
    if (abort_i) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      to_d    = '0;
      ti_d    = '0;
      ki_d    = '0;
      kj_d    = '0;
    end

    valid_d  = (state_d == RUN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    first_d  = valid_d && (ti_d == '0) && (ki_d == '0) && (kj_d == '0);
    last_d   = valid_d && (ti_d == TI_LAST) && (ki_d == K_LAST) && (kj_d == K_LAST);
    in_row_d = IR_W'(row_d) * IR_W'(S_p) + IR_W'(ki_d);
    in_col_d = IC_W'(col_d) * IC_W'(S_p) + IC_W'(kj_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      to_q     <= '0;
      ti_q     <= '0;
      ki_q     <= '0;
      kj_q     <= '0;
      in_row_q <= '0;
      in_col_q <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      to_q     <= to_d;
      ti_q     <= ti_d;
      ki_q     <= ki_d;
      kj_q     <= kj_d;
      in_row_q <= in_row_d;
      in_col_q <= in_col_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign beat.valid_o  = valid_q;
  assign beat.row_o    = row_q;
  assign beat.col_o    = col_q;
  assign beat.to_o     = to_q;
  assign beat.ti_o     = ti_q;
  assign beat.ki_o     = ki_q;
  assign beat.kj_o     = kj_q;
  assign beat.in_row_o = in_row_q;
  assign beat.in_col_o = in_col_q;
  assign beat.first_o  = first_q;
  assign beat.last_o   = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_cnn_tile_sched.sv
// Directed bench for cnn_tile_sched. Three instances cover the default layer,
// a 1x1 output with four maps (ordering/flags) and a stride-2, 3x3 kernel
// (input coordinate arithmetic). Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_cnn_tile_sched;

  localparam int TOTAL0 = 4096;

  logic clk;
  logic reset;
  logic start0, abort0, busy0, done0;
  logic start1, abort1, busy1, done1;
  logic start2, abort2, busy2, done2;

  int pass_count;
  int check_count;
  int fail_count;

  logic [27:0] exp_q [TOTAL0];

  cnn_tile_sched_if bus0 ();
  cnn_tile_sched_if #(.R_p(1), .C_p(1)) bus1 ();
  cnn_tile_sched_if #(.K_p(3), .S_p(2)) bus2 ();

  cnn_tile_sched dut0 (
    .clk(clk), .reset(reset), .start_i(start0), .abort_i(abort0),
    .busy_o(busy0), .done_o(done0), .beat(bus0)
  );

  cnn_tile_sched #(.R_p(1), .C_p(1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .abort_i(abort1),
    .busy_o(busy1), .done_o(done1), .beat(bus1)
  );

  cnn_tile_sched #(.K_p(3), .S_p(2)) dut2 (
    .clk(clk), .reset(reset), .start_i(start2), .abort_i(abort2),
    .busy_o(busy2), .done_o(done2), .beat(bus2)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] snap0();
    return {bus0.row_o, bus0.col_o, bus0.to_o, bus0.ti_o, bus0.ki_o, bus0.kj_o,
            bus0.first_o, bus0.last_o, bus0.in_row_o, bus0.in_col_o};
  endfunction

  task automatic check_idle0(input string tag);
    check_output({tag, " flags"},
                 {27'd0, bus0.valid_o, bus0.first_o, bus0.last_o, busy0, done0}, 32'd0);
    check_output({tag, " indices"}, {4'd0, snap0()}, 32'd0);
  endtask

  // One full default-layer pass with ready_i high duty_pct percent of cycles.
  task automatic run_pass0(input string tag, input int duty_pct);
    int beats, bad, stall_bad, cycles, done_seen;
    logic [27:0] held;
    bit stalled, rdy;
    beats = 0; bad = 0; stall_bad = 0; cycles = 0; done_seen = 0; stalled = 0;
    bus0.ready_i = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_output({tag, " latency valid/first"}, {30'd0, bus0.valid_o, bus0.first_o}, 32'd3);
    check_output({tag, " latency indices"}, {4'd0, snap0()}, {4'd0, exp_q[0]});
    while (beats < TOTAL0 && cycles < 40000) begin
      if (stalled && (snap0() !== held || bus0.valid_o !== 1'b1)) stall_bad++;
      rdy = (duty_pct >= 100) ? 1'b1 : ($urandom_range(99) < duty_pct);
      bus0.ready_i = rdy;
      if (done0) done_seen++;
      if (bus0.valid_o) begin
        if (rdy) begin
          if (snap0() !== exp_q[beats]) bad++;
          beats++;
          stalled = 0;
        end else begin
          held = snap0();
          stalled = 1;
        end
      end else begin
        bad++;
      end
      tick();
      cycles++;
    end
    check_output({tag, " beat count"}, beats, TOTAL0);
    check_output({tag, " sequence errors"}, bad, 0);
    check_output({tag, " stall errors"}, stall_bad, 0);
    check_output({tag, " early done"}, done_seen, 0);
    check_output({tag, " done cycle"}, {29'd0, done0, busy0, bus0.valid_o}, 32'b110);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_output({tag, " after done"}, {29'd0, done0, busy0, bus0.valid_o}, 32'b000);
    tick();
    check_output({tag, " start in DONE ignored"}, {31'd0, busy0}, 32'd0);
  endtask

  int t3_tbl [16][6] = '{
    '{0,0,0,0,1,0}, '{0,0,0,1,0,0}, '{0,0,1,0,0,0}, '{0,0,1,1,0,0},
    '{0,2,0,0,0,0}, '{0,2,0,1,0,0}, '{0,2,1,0,0,0}, '{0,2,1,1,0,1},
    '{2,0,0,0,1,0}, '{2,0,0,1,0,0}, '{2,0,1,0,0,0}, '{2,0,1,1,0,0},
    '{2,2,0,0,0,0}, '{2,2,0,1,0,0}, '{2,2,1,0,0,0}, '{2,2,1,1,0,1}
  };

  // Directed test sequence.
  initial begin
    int idx, found, cycles, done_hits;
    logic [10:0] exp_b;

    pass_count = 0; check_count = 0; fail_count = 0;
    clk = 1'b0; reset = 1'b1;
    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0; start2 = 0; abort2 = 0;
    bus0.ready_i = 0; bus1.ready_i = 0; bus2.ready_i = 0;

    // Expected default-layer beat order, outermost loop first.
    idx = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        for (int to = 0; to < 4; to += 2)
          for (int ti = 0; ti < 4; ti += 2)
            for (int ki = 0; ki < 2; ki++)
              for (int kj = 0; kj < 2; kj++) begin
                exp_q[idx] = {4'(r), 4'(c), 2'(to), 2'(ti), 2'(ki), 2'(kj),
                              (ti == 0 && ki == 0 && kj == 0),
                              (ti == 2 && ki == 1 && kj == 1),
                              5'(r + ki), 5'(c + kj)};
                idx++;
              end

    repeat (2) @(posedge clk);
    #1;
    check_idle0("reset held");
    reset = 1'b0;
    tick();
    check_idle0("reset released");

    $display("[TB] T1 asynchronous reset mid-run");
    bus0.ready_i = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (20) tick();
    check_output("T1 running", {31'd0, busy0}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_idle0("T1 async");
    #4 reset = 1'b0;
    tick();
    check_output("T1 idle after release", {30'd0, busy0, bus0.valid_o}, 32'd0);

    $display("[TB] T2 full pass, ready always high");
    run_pass0("T2", 100);

    $display("[TB] T4 full pass, ready at 30 percent");
    run_pass0("T4", 30);

    $display("[TB] T3 loop ordering");
    bus1.ready_i = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int b = 0; b < 16; b++) begin
      exp_b = {1'b1, 2'(t3_tbl[b][0]), 2'(t3_tbl[b][1]), 2'(t3_tbl[b][2]),
               2'(t3_tbl[b][3]), 1'(t3_tbl[b][4]), 1'(t3_tbl[b][5])};
      check_output($sformatf("T3 beat %0d", b + 1),
                   {21'd0, bus1.valid_o, bus1.to_o, bus1.ti_o, bus1.ki_o, bus1.kj_o,
                    bus1.first_o, bus1.last_o},
                   {21'd0, exp_b});
      tick();
    end
    check_output("T3 done", {30'd0, done1, bus1.valid_o}, 32'b10);

    $display("[TB] T5 stride 2, kernel 3");
    bus2.ready_i = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    found = 0;
    cycles = 0;
    while (!found && cycles < 5000) begin
      if (bus2.valid_o && bus2.row_o == 4'd3 && bus2.col_o == 4'd5 &&
          bus2.ki_o == 3'd2 && bus2.kj_o == 3'd1) found = 1;
      else begin
        tick();
        cycles++;
      end
    end
    check_output("T5 beat reached", found, 1);
    check_output("T5 in_row", {26'd0, bus2.in_row_o}, 32'd8);
    check_output("T5 in_col", {26'd0, bus2.in_col_o}, 32'd11);
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check_output("T5 abort idle", {31'd0, busy2}, 32'd0);

    $display("[TB] T6 abort and restart");
    bus0.ready_i = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (99) tick();
    check_output("T6 beat 100", {4'd0, snap0()}, {4'd0, exp_q[99]});
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check_idle0("T6 abort");
    done_hits = 0;
    repeat (5) begin
      tick();
      if (done0) done_hits++;
    end
    check_output("T6 no done", done_hits, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_output("T6 restart valid", {31'd0, bus0.valid_o}, 32'd1);
    check_output("T6 restart indices", {4'd0, snap0()}, {4'd0, exp_q[0]});
    repeat (10) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check_output("T6 start in RUN ignored", {4'd0, snap0()}, {4'd0, exp_q[11]});
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    start0 = 1'b1;
    abort0 = 1'b1;
    tick();
    start0 = 1'b0;
    abort0 = 1'b0;
    check_output("T6 start+abort idle", {30'd0, busy0, bus0.valid_o}, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
